pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/memory controller: stalls, flushes, forwarding selects, memory timeout abort.
// Latency: stall/flush/forward outputs combinational from inputs and registered state; state_o registered.
// Backpressure: dmem_req & !dmem_ack freezes PC, IF/DE and DE/MW; MEM_TIMEOUT waits abort the access.
// Optional: define PIPELINE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_valid,
  input  logic        de_redirect,
  input  logic [2:0]  de_rs1_addr,
  input  logic [2:0]  de_rs2_addr,
  input  logic [2:0]  mw_rd_addr,
  input  logic        mw_rd_we,
  input  logic        mw_mem_read_en,
  input  logic        mw_mem_write_en,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_stall,
  output logic        if_de_stall,
  output logic        de_mw_hold,
  output logic        if_de_flush,
  output logic        de_mw_flush,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        mem_err,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT    = 2'b01,
    ABORT   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       run_en;

  logic mem_acc;
  logic in_access;
  logic req_int;
  logic mem_stall;
  logic abort_now;
  logic redirect_flush;

  // A match on a load forwards memory data only in the ack cycle; before that the consumer is stalled.
  function automatic logic [1:0] fwd_sel(
    input logic [2:0] rs,
    input logic [2:0] rd,
    input logic       rd_we,
    input logic       ld,
    input logic       ack,
    input logic       enable
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (enable && rd_we && (rd != 3'd0) && (rs == rd)) begin
      if (!ld)
        sel = 2'd1;
      else if (ack)
        sel = 2'd2;
    end
    return sel;
  endfunction

  assign mem_acc        = mw_mem_read_en | mw_mem_write_en;
  assign in_access      = (state == RUN) || (state == WAIT);
  assign req_int        = run_en & mem_acc & in_access;
  assign mem_stall      = req_int & ~dmem_ack;
  assign abort_now      = run_en & (state == ABORT);
  assign redirect_flush = run_en & de_valid & de_redirect & ~mem_stall;

  assign dmem_req    = req_int;
  assign pc_stall    = mem_stall;
  assign if_de_stall = mem_stall;
  assign de_mw_hold  = mem_stall;
  assign if_de_flush = abort_now | redirect_flush;
  assign de_mw_flush = abort_now;
  assign mem_err     = abort_now;
  assign state_o     = run_en ? state : RUN;

  assign fwd_rs1_sel = fwd_sel(de_rs1_addr, mw_rd_addr, mw_rd_we, mw_mem_read_en,
                               dmem_ack & req_int, run_en & de_valid & ~abort_now);
  assign fwd_rs2_sel = fwd_sel(de_rs2_addr, mw_rd_addr, mw_rd_we, mw_mem_read_en,
                               dmem_ack & req_int, run_en & de_valid & ~abort_now);

  // Output enable: outputs stay gated until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      run_en <= 1'b0;
    else
      run_en <= 1'b1;
  end

  // Memory access FSM: RUN -> WAIT on an unacked access, WAIT -> ABORT after TIMEOUT waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 4'd0;
    end else if (run_en) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= 4'd1;
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        WAIT: begin
          // Leaving on ack, or if MW withdraws the access.
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == TIMEOUT) begin
            state    <= ABORT;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ABORT: begin
          state    <= RUN;
          wait_cnt <= 4'd0;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating performance counters for stall cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (mem_stall && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if ((if_de_flush || de_mw_flush) && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = run_en ? stall_q : 16'd0;
  assign flush_cnt = run_en ? flush_q : 16'd0;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: cycle-by-cycle expectations queued at drive time, compared mid-cycle.
// DUT built with MEM_TIMEOUT=4; counter expectations depend on PIPELINE_CTRL_PERF_EN.
// Inputs change on the falling edge; outputs sampled 2ns later, well away from the rising edge.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        de_valid, de_redirect;
  logic [2:0]  de_rs1_addr, de_rs2_addr, mw_rd_addr;
  logic        mw_rd_we, mw_mem_read_en, mw_mem_write_en;
  logic        dmem_req, dmem_ack;
  logic        pc_stall, if_de_stall, de_mw_hold;
  logic        if_de_flush, de_mw_flush;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        mem_err;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_valid(de_valid), .de_redirect(de_redirect),
    .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
    .mw_rd_addr(mw_rd_addr), .mw_rd_we(mw_rd_we),
    .mw_mem_read_en(mw_mem_read_en), .mw_mem_write_en(mw_mem_write_en),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .if_de_stall(if_de_stall), .de_mw_hold(de_mw_hold),
    .if_de_flush(if_de_flush), .de_mw_flush(de_mw_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .mem_err(mem_err), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv, redir;
    logic [2:0] rs1, rs2, rd;
    logic       we, mre, mwe, ack;
  } in_t;

  // Order matches the observed vector built in sample().
  typedef struct packed {
    logic       req;
    logic [2:0] stall;
    logic       ifl, mfl, err;
    logic [1:0] f1, f2, st;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic in_t mk_in(input logic dv, input logic redir,
                                input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                                input logic we, input logic mre, input logic mwe, input logic ack);
    return '{dv, redir, rs1, rs2, rd, we, mre, mwe, ack};
  endfunction

  function automatic exp_t mk_exp(input logic req, input logic stl, input logic ifl,
                                  input logic mfl, input logic err,
                                  input logic [1:0] f1, input logic [1:0] f2, input logic [1:0] st);
    return '{req, {3{stl}}, ifl, mfl, err, f1, f2, st};
  endfunction

  task automatic drive(input string tag, input in_t i, input exp_t e);
    de_valid        = i.dv;
    de_redirect     = i.redir;
    de_rs1_addr     = i.rs1;
    de_rs2_addr     = i.rs2;
    mw_rd_addr      = i.rd;
    mw_rd_we        = i.we;
    mw_mem_read_en  = i.mre;
    mw_mem_write_en = i.mwe;
    dmem_ack        = i.ack;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    logic [12:0] obs;
    exp_t        e;
    string       t;
    chk("sb_pending", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      obs = {dmem_req, pc_stall, if_de_stall, de_mw_hold, if_de_flush, de_mw_flush,
             mem_err, fwd_rs1_sel, fwd_rs2_sel, state_o};
      chk(t, 32'(obs), 32'(e));
    end
  endtask

  task automatic step(input string tag, input in_t i, input exp_t e);
    @(negedge clk);
    drive(tag, i, e);
    #2;
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  idle, aggr;
    exp_t zero;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    aggr = mk_in(1, 1, 3, 3, 3, 1, 1, 0, 0);
    zero = mk_exp(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset: outputs gated even with inputs that would otherwise drive them.
    rst_n = 1'b0;
    drive("rst_hold", aggr, zero);
    #2;
    sample();
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    drive("rst_release", aggr, zero);
    rst_n = 1'b1;
    #2;
    sample();

    // Zero-wait load with rd match on rs1.
    step("ld_zero_wait", mk_in(1, 0, 3, 5, 3, 1, 1, 0, 1), mk_exp(1, 0, 0, 0, 0, 2, 0, 0));

    // Store with three wait cycles, ack on the fourth.
    step("st_w1", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 0));
    step("st_w2", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1));
    step("st_w3", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1));
    step("st_ack", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1), mk_exp(1, 0, 0, 0, 0, 0, 0, 1));
    step("st_done", idle, zero);
    chk("st_stall_cnt", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
    chk("st_flush_cnt", 32'(flush_cnt), 32'd0);

    // Redirect held during a two-cycle wait: flush only in the ack cycle.
    step("rd_w1", mk_in(1, 1, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 0));
    step("rd_w2", mk_in(1, 1, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1));
    step("rd_ack", mk_in(1, 1, 0, 0, 0, 0, 0, 1, 1), mk_exp(1, 0, 1, 0, 0, 0, 0, 1));
    step("rd_done", idle, zero);
    chk("rd_stall_cnt", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
    chk("rd_flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

    // Load with one wait: no forward while stalled, memory data on ack for both sources.
    step("ldw_wait", mk_in(1, 0, 3, 3, 3, 1, 1, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 0));
    step("ldw_ack", mk_in(1, 0, 3, 3, 3, 1, 1, 0, 1), mk_exp(1, 0, 0, 0, 0, 2, 2, 1));
    step("ldw_done", idle, zero);

    // ALU forwarding and its qualifiers.
    step("fwd_alu", mk_in(1, 0, 3, 0, 3, 1, 0, 0, 0), mk_exp(0, 0, 0, 0, 0, 1, 0, 0));
    step("fwd_rd0", mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0), zero);
    step("fwd_dv0", mk_in(0, 0, 3, 3, 3, 1, 0, 0, 0), zero);
    step("fwd_we0", mk_in(1, 0, 3, 3, 3, 0, 0, 0, 0), zero);
    step("fwd_rs2", mk_in(1, 0, 1, 6, 6, 1, 0, 0, 0), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
    step("ack_idle", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), zero);
    step("ack_idle_next", idle, zero);

    // Redirect without stall flushes IF/DE only.
    step("redir_now", mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0), mk_exp(0, 0, 1, 0, 0, 0, 0, 0));
    step("redir_done", idle, zero);
    chk("redir_flush_cnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);

    // Timeout: RUN stall cycle, four WAIT cycles, one ABORT cycle (late ack ignored), then RUN.
    step("to_run", mk_in(1, 0, 3, 0, 3, 1, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 4; k++)
      step($sformatf("to_wait%0d", k), mk_in(1, 0, 3, 0, 3, 1, 0, 1, 0),
           mk_exp(1, 1, 0, 0, 0, 1, 0, 1));
    step("to_abort", mk_in(1, 0, 3, 0, 3, 1, 0, 1, 1), mk_exp(0, 0, 1, 1, 1, 0, 0, 2));
    step("to_back_run", idle, zero);
    chk("to_stall_cnt", 32'(stall_cnt), PERF ? 32'd11 : 32'd0);
    chk("to_flush_cnt", 32'(flush_cnt), PERF ? 32'd3 : 32'd0);

    // Reset asserted mid-WAIT.
    step("rw_run", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 0));
    step("rw_wait", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b0;
    drive("rw_async", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), zero);
    #1;
    sample();
    chk("rw_async_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    drive("rw_release", aggr, zero);
    rst_n = 1'b1;
    #2;
    sample();
    step("rw_normal", mk_in(1, 0, 3, 0, 3, 1, 0, 1, 1), mk_exp(1, 0, 0, 0, 0, 1, 0, 0));
    step("rw_done", idle, zero);
    chk("rw_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rw_flush_cnt", 32'(flush_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
